// File: rtl/tcp_pkg.sv
// Shared types and constants for the TCP transmit path.
package tcp_pkg;

  typedef enum logic [2:0] {
    TX_CTRL_NONE     = 3'd0,
    TX_CTRL_SEND_SYN = 3'd1,
    TX_CTRL_SEND_ACK = 3'd2,
    TX_CTRL_SEND_FIN = 3'd3,
    TX_CTRL_SEND_RST = 3'd4
  } tx_ctrl_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_SYN,
    ST_SEND_ACK,
    ST_SEND_FIN,
    ST_SEND_RST,
    ST_SEND_DATA,
    ST_RETX
  } tx_state_e;

  localparam logic [7:0] FLAG_FIN = 8'h01;
  localparam logic [7:0] FLAG_SYN = 8'h02;
  localparam logic [7:0] FLAG_RST = 8'h04;
  localparam logic [7:0] FLAG_PSH = 8'h08;
  localparam logic [7:0] FLAG_ACK = 8'h10;
  localparam logic [7:0] FLAG_URG = 8'h20;
  localparam logic [7:0] FLAG_ECE = 8'h40;
  localparam logic [7:0] FLAG_CWR = 8'h80;

  localparam logic [15:0] TCP_IP_HDR_LEN = 16'd40;

endpackage

// File: rtl/tcp_retx_timer.sv
// Retransmission timer: saturating cycle counter plus bounded retry count.
module tcp_retx_timer #(
  parameter int unsigned RTO_CYCLES  = 1_000_000,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_restart,
  input  logic i_retry_clr,
  input  logic i_retry_inc,
  output logic o_expire,
  output logic o_fail
);

  localparam int CW = (RTO_CYCLES > 1) ? $clog2(RTO_CYCLES) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(RTO_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retries_q, retries_d;
  logic          at_last;

  assign at_last  = (cnt_q == CNT_LAST);
  // Counter parks at the last value so an expiry seen outside IDLE stays pending.
  assign o_expire = i_run && at_last && (retries_q != RETRY_MAX);
  assign o_fail   = i_run && at_last && (retries_q == RETRY_MAX);

  always_comb begin
    cnt_d     = cnt_q;
    retries_d = retries_q;
    if (i_restart)             cnt_d = '0;
    else if (i_run && !at_last) cnt_d = cnt_q + 1'b1;
    if (i_retry_clr)                                 retries_d = '0;
    else if (i_retry_inc && retries_q != RETRY_MAX)  retries_d = retries_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      retries_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
    end
  end

endmodule

// File: rtl/tcp_tx_seq_ctrl.sv
// TCP transmit sequencer: picks the next segment header, tracks snd_una/snd_nxt,
// gates payload on window/MSS and retransmits outstanding SYN/FIN.
module tcp_tx_seq_ctrl
  import tcp_pkg::*;
#(
  parameter logic [31:0] ISN         = 32'h0000_0000,
  parameter logic [15:0] RCV_WINDOW  = 16'h0100,
  parameter int unsigned MSS         = 1460,
  parameter int unsigned RTO_CYCLES  = 1_000_000,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  tx_ctrl_t    i_tx_ctrl,
  input  logic        i_tx_ctrl_valid,
  output logic        o_tx_ctrl_ack,
  input  logic        i_data_valid,
  input  logic [15:0] i_data_len,
  output logic        o_data_grant,
  output logic        o_data_blocked,
  input  logic        i_rcv_ack_valid,
  input  logic [31:0] i_rcv_ack_number,
  input  logic [31:0] i_rcv_nxt,
  input  logic [15:0] i_peer_window,
  output logic        o_no_data,
  output logic [15:0] o_ip_len,
  output logic [31:0] o_seq_number,
  output logic [31:0] o_ack_number,
  output logic [7:0]  o_flags,
  output logic [15:0] o_window_size,
  output logic        o_hdr_valid,
  input  logic        i_packet_done,
  output logic        o_retx_fail,
  output logic [31:0] o_inflight
);

  localparam logic [31:0] MSS_W = 32'(MSS);

  tx_state_e   state_q, state_d;
  logic [31:0] snd_una_q, snd_una_d, snd_nxt_q, snd_nxt_d;
  logic        pending_q, pending_d;
  logic [7:0]  pflags_q, pflags_d;
  logic [31:0] seq_q, seq_d;
  logic [7:0]  flags_q, flags_d;
  logic [15:0] ip_len_q, ip_len_d, dlen_q, dlen_d;
  logic        no_data_q, no_data_d;

  logic        t_restart, t_retry_clr, t_retry_inc, t_expire, t_fail;
  logic [31:0] inflight, ack_off;
  logic [32:0] room;
  logic        eligible, ack_ok;

  tcp_retx_timer #(.RTO_CYCLES(RTO_CYCLES), .MAX_RETRIES(MAX_RETRIES)) u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_run       (pending_q && state_q != ST_RETX),
    .i_restart   (t_restart),
    .i_retry_clr (t_retry_clr),
    .i_retry_inc (t_retry_inc),
    .o_expire    (t_expire),
    .o_fail      (t_fail)
  );

  assign inflight = snd_nxt_q - snd_una_q;
  assign ack_off  = i_rcv_ack_number - snd_una_q;
  assign ack_ok   = i_rcv_ack_valid && (ack_off != 32'd0) && (ack_off <= inflight);
  // Widened subtract: a window smaller than inflight goes negative and blocks data.
  assign room     = {17'd0, i_peer_window} - {1'b0, inflight};
  assign eligible = i_data_valid && (i_data_len != 16'd0) && ({16'd0, i_data_len} <= MSS_W)
                 && !room[32] && ({17'd0, i_data_len} <= room);

  always_comb begin
    state_d     = state_q;
    snd_una_d   = snd_una_q;
    snd_nxt_d   = snd_nxt_q;
    pending_d   = pending_q;
    pflags_d    = pflags_q;
    seq_d       = seq_q;
    flags_d     = flags_q;
    ip_len_d    = ip_len_q;
    no_data_d   = no_data_q;
    dlen_d      = dlen_q;
    t_restart   = 1'b0;
    t_retry_clr = 1'b0;
    t_retry_inc = 1'b0;
    o_tx_ctrl_ack = 1'b0;

    if (ack_ok) begin
      snd_una_d = i_rcv_ack_number;
      if (i_rcv_ack_number == snd_nxt_q) begin
        pending_d   = 1'b0;
        t_restart   = 1'b1;
        t_retry_clr = 1'b1;
      end
    end
    if (t_fail) begin
      pending_d = 1'b0;
      t_restart = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        ip_len_d  = TCP_IP_HDR_LEN;
        no_data_d = 1'b1;
        seq_d     = snd_nxt_q;
        if (t_expire) begin
          state_d = ST_RETX;
          seq_d   = snd_una_q;
          flags_d = pflags_q;
        end else if (i_tx_ctrl_valid) begin
          o_tx_ctrl_ack = 1'b1;
          case (i_tx_ctrl)
            TX_CTRL_SEND_SYN: begin state_d = ST_SEND_SYN; flags_d = FLAG_SYN; end
            TX_CTRL_SEND_ACK: begin state_d = ST_SEND_ACK; flags_d = FLAG_ACK; end
            TX_CTRL_SEND_FIN: begin state_d = ST_SEND_FIN; flags_d = FLAG_ACK | FLAG_FIN; end
            TX_CTRL_SEND_RST: begin state_d = ST_SEND_RST; flags_d = FLAG_RST | FLAG_ACK; end
            default: ;
          endcase
        end else if (eligible) begin
          state_d   = ST_SEND_DATA;
          flags_d   = FLAG_ACK | FLAG_PSH;
          ip_len_d  = TCP_IP_HDR_LEN + i_data_len;
          no_data_d = 1'b0;
          dlen_d    = i_data_len;
        end else begin
          seq_d     = seq_q;
          ip_len_d  = ip_len_q;
          no_data_d = no_data_q;
        end
      end
      default: begin
        if (i_packet_done) begin
          state_d = ST_IDLE;
          case (state_q)
            ST_SEND_SYN: begin
              snd_nxt_d   = snd_nxt_q + 32'd1;
              pending_d   = 1'b1;
              pflags_d    = FLAG_SYN;
              t_restart   = 1'b1;
              t_retry_clr = 1'b1;
            end
            ST_SEND_FIN: begin
              snd_nxt_d = snd_nxt_q + 32'd1;
              pending_d = 1'b1;
              pflags_d  = FLAG_ACK | FLAG_FIN;
              t_restart = 1'b1;
            end
            ST_SEND_RST: begin
              pending_d = 1'b0;
              t_restart = 1'b1;
            end
            ST_SEND_DATA: snd_nxt_d = snd_nxt_q + {16'd0, dlen_q};
            ST_RETX: begin
              t_retry_inc = 1'b1;
              t_restart   = 1'b1;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      snd_una_q <= ISN;
      snd_nxt_q <= ISN;
      pending_q <= 1'b0;
      pflags_q  <= 8'h00;
      seq_q     <= ISN;
      flags_q   <= 8'h00;
      ip_len_q  <= TCP_IP_HDR_LEN;
      no_data_q <= 1'b1;
      dlen_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      snd_una_q <= snd_una_d;
      snd_nxt_q <= snd_nxt_d;
      pending_q <= pending_d;
      pflags_q  <= pflags_d;
      seq_q     <= seq_d;
      flags_q   <= flags_d;
      ip_len_q  <= ip_len_d;
      no_data_q <= no_data_d;
      dlen_q    <= dlen_d;
    end
  end

  assign o_hdr_valid    = (state_q != ST_IDLE);
  assign o_data_grant   = (state_q == ST_SEND_DATA);
  assign o_data_blocked = i_data_valid && !eligible;
  assign o_seq_number   = seq_q;
  assign o_flags        = flags_q;
  assign o_ip_len       = ip_len_q;
  assign o_no_data      = no_data_q;
  assign o_window_size  = RCV_WINDOW;
  assign o_retx_fail    = t_fail;
  assign o_inflight     = inflight;
  assign o_ack_number   = ((state_q == ST_SEND_SYN) || (state_q == ST_RETX && flags_q == FLAG_SYN))
                          ? 32'd0 : i_rcv_nxt;

endmodule

// File: tb/tb_tcp_tx_seq_ctrl.sv
// Directed bench for tcp_tx_seq_ctrl with a wrapping ISN and a short RTO.
module tb_tcp_tx_seq_ctrl;
  import tcp_pkg::*;

  localparam logic [31:0] ISN = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  tx_ctrl_t    i_tx_ctrl = TX_CTRL_NONE;
  logic        i_tx_ctrl_valid = 1'b0, o_tx_ctrl_ack;
  logic        i_data_valid = 1'b0;
  logic [15:0] i_data_len = 16'd0;
  logic        o_data_grant, o_data_blocked;
  logic        i_rcv_ack_valid = 1'b0;
  logic [31:0] i_rcv_ack_number = 32'd0;
  logic [31:0] i_rcv_nxt = 32'h1234_5678;
  logic [15:0] i_peer_window = 16'hFFFF;
  logic        o_no_data;
  logic [15:0] o_ip_len;
  logic [31:0] o_seq_number, o_ack_number;
  logic [7:0]  o_flags;
  logic [15:0] o_window_size;
  logic        o_hdr_valid;
  logic        i_packet_done = 1'b0;
  logic        o_retx_fail;
  logic [31:0] o_inflight;

  tcp_tx_seq_ctrl #(.ISN(ISN), .RCV_WINDOW(16'h0100), .MSS(1460),
                    .RTO_CYCLES(16), .MAX_RETRIES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_tx_ctrl(i_tx_ctrl), .i_tx_ctrl_valid(i_tx_ctrl_valid), .o_tx_ctrl_ack(o_tx_ctrl_ack),
    .i_data_valid(i_data_valid), .i_data_len(i_data_len),
    .o_data_grant(o_data_grant), .o_data_blocked(o_data_blocked),
    .i_rcv_ack_valid(i_rcv_ack_valid), .i_rcv_ack_number(i_rcv_ack_number),
    .i_rcv_nxt(i_rcv_nxt), .i_peer_window(i_peer_window),
    .o_no_data(o_no_data), .o_ip_len(o_ip_len), .o_seq_number(o_seq_number),
    .o_ack_number(o_ack_number), .o_flags(o_flags), .o_window_size(o_window_size),
    .o_hdr_valid(o_hdr_valid), .i_packet_done(i_packet_done),
    .o_retx_fail(o_retx_fail), .o_inflight(o_inflight)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_tx_ctrl_valid = 1'b0; i_data_valid = 1'b0;
    i_rcv_ack_valid = 1'b0; i_packet_done = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
  endtask

  task automatic done_pulse();
    i_packet_done = 1'b1; tick(); i_packet_done = 1'b0;
  endtask

  task automatic wait_hdr(input string tag, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (o_hdr_valid) break;
      tick();
    end
    chk(tag, 32'(o_hdr_valid), 32'd1);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      tick();
      if (o_hdr_valid) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  task automatic send_ack(input logic [31:0] num);
    i_rcv_ack_valid = 1'b1; i_rcv_ack_number = num;
    tick();
    i_rcv_ack_valid = 1'b0;
  endtask

  task automatic req(input tx_ctrl_t c);
    i_tx_ctrl = c; i_tx_ctrl_valid = 1'b1; #1;
    chk("ctrl_ack", 32'(o_tx_ctrl_ack), 32'd1);
    tick();
    i_tx_ctrl_valid = 1'b0;
  endtask

  initial begin
    int fail_seen, hdr_seen;

    // 1/2: reset state, SYN with wrapping ISN, full ack at 0
    do_reset();
    chk("rst_hdr_valid", 32'(o_hdr_valid), 32'd0);
    chk("rst_flags", 32'(o_flags), 32'd0);
    chk("rst_ip_len", 32'(o_ip_len), 32'd40);
    chk("rst_inflight", o_inflight, 32'd0);
    chk("rst_seq", o_seq_number, ISN);
    chk("rst_fail", 32'(o_retx_fail), 32'd0);
    chk("window", 32'(o_window_size), 32'h100);
    req(TX_CTRL_SEND_SYN);
    chk("syn_valid", 32'(o_hdr_valid), 32'd1);
    chk("syn_flags", 32'(o_flags), 32'h02);
    chk("syn_seq", o_seq_number, ISN);
    chk("syn_acknum", o_ack_number, 32'd0);
    chk("syn_nodata", 32'(o_no_data), 32'd1);
    done_pulse();
    chk("syn_idle", 32'(o_hdr_valid), 32'd0);
    chk("syn_inflight", o_inflight, 32'd1);
    send_ack(32'd0);
    chk("syn_acked", o_inflight, 32'd0);
    quiet("syn_no_retx", 40);

    // 3: SYN never acked -> two retransmits then failure
    do_reset();
    req(TX_CTRL_SEND_SYN);
    done_pulse();
    wait_hdr("retx1_wait", 40);
    chk("retx1_flags", 32'(o_flags), 32'h02);
    chk("retx1_seq", o_seq_number, ISN);
    chk("retx1_acknum", o_ack_number, 32'd0);
    done_pulse();
    wait_hdr("retx2_wait", 40);
    chk("retx2_seq", o_seq_number, ISN);
    done_pulse();
    fail_seen = 0; hdr_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_hdr_valid) hdr_seen++;
      if (o_retx_fail) begin fail_seen = 1; break; end
    end
    chk("retx_fail_pulse", 32'(fail_seen), 32'd1);
    chk("retx_no_third", 32'(hdr_seen), 32'd0);
    tick();
    chk("retx_fail_1cyc", 32'(o_retx_fail), 32'd0);
    chk("retx_inflight", o_inflight, 32'd1);
    quiet("retx_gave_up", 40);

    // 4: window gating
    do_reset();
    i_peer_window = 16'd100;
    i_data_valid = 1'b1; i_data_len = 16'd60; #1;
    chk("d1_blocked", 32'(o_data_blocked), 32'd0);
    tick();
    chk("d1_grant", 32'(o_data_grant), 32'd1);
    chk("d1_flags", 32'(o_flags), 32'h18);
    chk("d1_ip_len", 32'(o_ip_len), 32'd100);
    chk("d1_seq", o_seq_number, ISN);
    chk("d1_nodata", 32'(o_no_data), 32'd0);
    chk("d1_acknum", o_ack_number, 32'h1234_5678);
    done_pulse();
    chk("d1_inflight", o_inflight, 32'd60);
    chk("d2_blocked", 32'(o_data_blocked), 32'd1);
    quiet("d2_held", 5);
    send_ack(32'h0000_003C);
    chk("bad_ack_ignored", o_inflight, 32'd60);
    send_ack(32'h0000_003B);
    chk("d2_acked", o_inflight, 32'd0);
    chk("d2_unblocked", 32'(o_data_blocked), 32'd0);
    tick();
    chk("d2_grant", 32'(o_data_grant), 32'd1);
    chk("d2_seq", o_seq_number, 32'h0000_003B);
    done_pulse();
    chk("d2_inflight", o_inflight, 32'd60);
    i_data_valid = 1'b0;

    // 5: MSS limit, ctrl request wins over data
    do_reset();
    i_peer_window = 16'hFFFF;
    i_data_valid = 1'b1; i_data_len = 16'd1461; #1;
    chk("mss_blocked", 32'(o_data_blocked), 32'd1);
    quiet("mss_no_grant", 5);
    i_data_len = 16'd1460;
    req(TX_CTRL_SEND_ACK);
    chk("ack_flags", 32'(o_flags), 32'h10);
    chk("ack_no_grant", 32'(o_data_grant), 32'd0);
    chk("ack_seq", o_seq_number, ISN);
    done_pulse();
    tick();
    chk("mss_grant", 32'(o_data_grant), 32'd1);
    chk("mss_ip_len", 32'(o_ip_len), 32'd1500);

    // 6: reset during SEND_DATA
    i_rst = 1'b1; tick();
    chk("abort_hdr", 32'(o_hdr_valid), 32'd0);
    chk("abort_seq", o_seq_number, ISN);
    i_rst = 1'b0; i_data_valid = 1'b0;
    done_pulse();
    chk("stray_done_inflight", o_inflight, 32'd0);
    chk("stray_done_hdr", 32'(o_hdr_valid), 32'd0);

    // FIN then RST clears pending
    req(TX_CTRL_SEND_FIN);
    chk("fin_flags", 32'(o_flags), 32'h11);
    chk("fin_acknum", o_ack_number, 32'h1234_5678);
    done_pulse();
    chk("fin_inflight", o_inflight, 32'd1);
    req(TX_CTRL_SEND_RST);
    chk("rst_flags_seg", 32'(o_flags), 32'h14);
    chk("rst_seq_seg", o_seq_number, 32'd0);
    done_pulse();
    quiet("rst_no_retx", 40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tcp_tx_seq_ctrl.md
Name: tcp_tx_seq_ctrl

Overview:
Parametrised successor to the TCP transmit header controller. It sequences SYN/ACK/FIN/RST/data segment headers toward the TCP header builder. It tracks snd_una/snd_nxt, gates data against the peer's advertised window and MSS, and retransmits unacknowledged SYN/FIN on a timeout with bounded retries. It sits between the TCP state machine / payload FIFO and the header/packet assembler.

Parameters:
ISN, 32'h0000_0000, initial sequence number loaded into snd_una/snd_nxt at reset
RCV_WINDOW, 16'h0100, value driven on o_window_size
MSS, 1460, maximum payload bytes per data segment
RTO_CYCLES, 1_000_000, i_clk cycles before an outstanding SYN/FIN is retransmitted
MAX_RETRIES, 3, retransmissions allowed before giving up

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_tx_ctrl  in  tcp_pkg::tx_ctrl_t  SYN/ACK/FIN/RST request
i_tx_ctrl_valid  in  1  request valid; held until o_tx_ctrl_ack
o_tx_ctrl_ack  out  1  one-cycle accept pulse
i_data_valid  in  1  payload segment waiting upstream
i_data_len  in  16  payload bytes of waiting segment, stable while i_data_valid
o_data_grant  out  1  high throughout SEND_DATA; upstream streams payload
o_data_blocked  out  1  data waiting but refused (len>MSS or window)
i_rcv_ack_valid  in  1  received segment carried ACK
i_rcv_ack_number  in  32  its acknowledgement number
i_rcv_nxt  in  32  next expected peer seq; driven on o_ack_number
i_peer_window  in  16  peer advertised window
o_no_data  out  1  header-only segment
o_ip_len  out  16  IP total length
o_seq_number  out  32  segment sequence number
o_ack_number  out  32  segment ack number
o_flags  out  8  TCP flags
o_window_size  out  16  RCV_WINDOW
o_hdr_valid  out  1  header fields valid; held until i_packet_done
i_packet_done  in  1  assembler finished segment
o_retx_fail  out  1  one-cycle pulse: retries exhausted
o_inflight  out  32  snd_nxt - snd_una

Behaviour:
- Reset (i_rst, synchronous, active-high; clock i_clk): state IDLE; snd_una=snd_nxt=ISN; timer, retry count and pending flag cleared; all valid/pulse outputs 0; o_flags=0, o_ip_len=40, o_inflight=0. Reset mid-segment aborts it with no sequence update.
- States: IDLE, SEND_SYN, SEND_ACK, SEND_FIN, SEND_RST, SEND_DATA, RETX.
- IDLE priority, evaluated in one cycle: (1) retransmit expiry -> RETX; (2) i_tx_ctrl_valid -> o_tx_ctrl_ack=1 and go to the matching SEND_x; (3) data eligible -> SEND_DATA. Transitions take effect the next cycle; o_hdr_valid=0 in IDLE.
- Data eligible when i_data_valid, 1<=i_data_len<=MSS, and i_data_len <= i_peer_window - o_inflight (17-bit compare; negative result means ineligible). Otherwise, with i_data_valid=1, o_data_blocked=1.
- Every SEND state and RETX assert o_hdr_valid, hold all header fields constant, and exit to IDLE on the cycle after i_packet_done.
- i_packet_done outside a SEND/RETX state is ignored.
- Per-state header fields and effect on packet_done:
  - SYN: flags SYN, seq=snd_nxt, ip_len=40, no_data=1. Done: snd_nxt+=1, pending=1, timer restarts, retries=0.
  - ACK: flags ACK, seq=snd_nxt. No sequence change.
  - FIN: flags ACK|FIN, seq=snd_nxt. Done: snd_nxt+=1, pending=1, timer restarts.
  - RST: flags RST|ACK, seq=snd_nxt. Done: pending and timer cleared; no sequence change.
  - DATA: flags ACK|PSH, seq=snd_nxt, ip_len=40+i_data_len (16-bit), no_data=0, o_data_grant=1. Done: snd_nxt+=i_data_len, latched at entry.
  - RETX: flags as originally sent (SYN, or ACK|FIN, stored in a pending_flags register), seq=snd_una. Done: retries+=1, timer restarts.
- o_ack_number = i_rcv_nxt in every state except SYN-only (0).
- ACK processing, any state, every cycle: when i_rcv_ack_valid and 0 < (ack - snd_una) <= (snd_nxt - snd_una) (mod 2^32), snd_una<=ack. If ack==snd_nxt, clear pending, timer and retries. Other acks are ignored.
- On the same cycle as i_packet_done, the acceptance check uses pre-update snd_nxt.
- Timer counts only while pending and not in RETX. It expires at RTO_CYCLES-1. Expiry with retries==MAX_RETRIES: pulse o_retx_fail, clear pending, no RETX.
- All sequence arithmetic is modulo 2^32; wrap-around is legal.

Decomposition:
- tcp_pkg: tx_ctrl_t extended with TX_CTRL_SEND_RST; FLAG_FIN..FLAG_CWR constants; TCP_IP_HDR_LEN=40.
- One sub-module: tcp_retx_timer (count, restart, clear, expire pulse, retry counter, fail pulse). Parameters RTO_CYCLES and MAX_RETRIES.

Test Plan:
1. Reset, then SYN request -> ack pulse; header flags=0x02, seq=ISN. After done, o_inflight=1. Ack ISN+1 -> inflight=0, no RETX.
2. ISN=32'hFFFF_FFFF, SYN done, ack=0 -> snd_una=0 accepted, pending cleared (wrap).
3. SYN with no ack, RTO_CYCLES=16, MAX_RETRIES=2 -> two RETX headers with seq=ISN. At third expiry, o_retx_fail pulse and return to IDLE.
4. peer_window=100, data len 60 then len 60 -> first sent (ip_len=100, flags=0x18, seq advances 60). Second blocked, o_data_blocked=1, until ack raises snd_una, then sent.
5. i_data_len=MSS+1 -> never granted, o_data_blocked=1. Simultaneous ctrl ACK request and data -> ACK served first.
6. i_rst asserted mid-SEND_DATA -> next cycle o_hdr_valid=0, seq=ISN; a later i_packet_done is ignored.
